// File: rtl/irq_pend_pkg.sv
// rtl/irq_pend_pkg.sv - shared constants, FSM states and priority helper for irq_pend_arb4
package irq_pend_pkg;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {ST_IDLE, ST_OFFER, ST_GAP} state_e;

    // Highest set index wins; an empty vector encodes to 0.
    function automatic logic [ID_W-1:0] prio4(input logic [N_REQ-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) r = ID_W'(i);
        end
        return r;
    endfunction
endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - one request line: synchroniser plus edge or level set detect
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    output logic set_pulse_o,
    output logic new_pulse_o
);
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
    end

    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic prev_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) prev_q <= 1'b0;
                else        prev_q <= sync_q[SYNC_STAGES-1];
            end
            assign set_pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;
            assign new_pulse_o = set_pulse_o;
        end else begin : g_level
            // Level mode taps one stage early: the pending flop is the last resolving stage.
            // Only a fresh assertion of the level can be a lost request.
            assign set_pulse_o = sync_q[SYNC_STAGES-2];
            assign new_pulse_o = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
        end
    endgenerate
endmodule

// File: rtl/irq_pend_arb4.sv
// rtl/irq_pend_arb4.sv - sticky pending capture, masked priority pick and valid/ready ID offer
module irq_pend_arb4
    import irq_pend_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1,
    parameter int OVF_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_i,
    input  logic [3:0]       mask_i,
    output logic [1:0]       id_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [3:0]       pending_o,
    output logic [OVF_W-1:0] ovf_cnt_o
);
    logic [N_REQ-1:0] set_pulse, new_pulse;
    logic [N_REQ-1:0] pending_q, pending_d, clr, lost, eligible;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic [ID_W-1:0]  id_q, id_d;
    state_e           state_q, state_d;
    logic             accept;

    for (genvar k = 0; k < N_REQ; k++) begin : g_line
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_MODE(EDGE_MODE)) u_sync (
            .clk         (clk),
            .rst_n       (rst_n),
            .req_i       (req_i[k]),
            .set_pulse_o (set_pulse[k]),
            .new_pulse_o (new_pulse[k])
        );
    end

    // A set landing on the bit being cleared wins and is not a loss.
    always_comb begin
        accept    = (state_q == ST_OFFER) && ready_i;
        clr       = accept ? (N_REQ'(1) << id_q) : '0;
        lost      = new_pulse & pending_q & ~clr;
        pending_d = (pending_q & ~clr) | set_pulse;
        eligible  = pending_q & mask_i;
        ovf_d     = ovf_q;
        if ((|lost) && !(&ovf_q)) ovf_d = ovf_q + OVF_W'(1);
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    id_d    = prio4(eligible);
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: if (ready_i) state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign valid_o   = (state_q == ST_OFFER);
    assign id_o      = id_q;
    assign pending_o = pending_q;
    assign ovf_cnt_o = ovf_q;
endmodule

// File: tb/tb_irq_pend_arb4.sv
// tb/tb_irq_pend_arb4.sv - self-checking bench for irq_pend_arb4
module tb_irq_pend_arb4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'h0, mask = 4'hF, req_l = 4'h0;
    logic       rdy = 1'b0, rdy_l = 1'b0;
    logic [1:0] id0, id1, id2;
    logic       v0, v1, v2;
    logic [3:0] p0, p1, p2;
    logic [7:0] o0, o1;
    logic [1:0] o2;

    always #5 clk = ~clk;

    irq_pend_arb4 dut (.clk(clk), .rst_n(rst_n), .req_i(req), .mask_i(mask), .id_o(id0),
        .valid_o(v0), .ready_i(rdy), .pending_o(p0), .ovf_cnt_o(o0));
    irq_pend_arb4 #(.EDGE_MODE(0)) dut_lvl (.clk(clk), .rst_n(rst_n), .req_i(req_l), .mask_i(4'hF),
        .id_o(id1), .valid_o(v1), .ready_i(rdy_l), .pending_o(p1), .ovf_cnt_o(o1));
    irq_pend_arb4 #(.OVF_W(2)) dut_sat (.clk(clk), .rst_n(rst_n), .req_i(req), .mask_i(mask),
        .id_o(id2), .valid_o(v2), .ready_i(rdy), .pending_o(p2), .ovf_cnt_o(o2));

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a line's set event is a 0->1 step of req seen three
    // and two samples back; offers run as offer slot, one cooldown cycle, then arbitration.
    bit [3:0] m_pend, m_h0, m_h1, m_h2;
    int       m_ovf, m_ovf2;
    bit       m_offer, m_gap;
    int       m_id;

    function automatic int top_bit(input bit [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_h0 = 0; m_h1 = 0; m_h2 = 0;
        m_ovf = 0; m_ovf2 = 0; m_offer = 0; m_gap = 0; m_id = 0;
    endtask

    task automatic model_step();
        bit [3:0] set, clr, elig;
        set  = m_h1 & ~m_h2;
        clr  = 0;
        elig = m_pend & mask;
        if (m_offer && rdy) clr[m_id] = 1'b1;
        if ((set & m_pend & ~clr) != 0) begin
            if (m_ovf < 255) m_ovf++;
            if (m_ovf2 < 3) m_ovf2++;
        end
        if (m_offer) begin
            if (rdy) begin m_offer = 0; m_gap = 1; end
        end else if (m_gap) m_gap = 0;
        else if (elig != 0) begin m_offer = 1; m_id = top_bit(elig); end
        m_pend = (m_pend & ~clr) | set;
        m_h2 = m_h1; m_h1 = m_h0; m_h0 = req;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_pending", p0, m_pend);
        check("model_valid", v0, m_offer);
        if (m_offer) check("model_id", id0, m_id);
        check("model_ovf", o0, m_ovf);
        check("model_ovf_sat", o2, m_ovf2);
    endtask

    typedef struct {
        bit [3:0] req;
        bit       rdy;
        bit [3:0] pend;
        bit       valid;
        bit [1:0] id;
    } vec_t;
    vec_t tbl[18];
    int   offers;

    initial begin
        model_reset();
        #1;
        check("rst_valid", v0, 0);
        check("rst_pending", p0, 0);
        check("rst_ovf", o0, 0);
        check("rst_id", id0, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Test 1 then test 2, mask all enabled
        tbl[0]  = '{4'b0010, 0, 4'b0000, 0, 0};
        tbl[1]  = '{4'b0000, 0, 4'b0000, 0, 0};
        tbl[2]  = '{4'b0000, 0, 4'b0010, 0, 0};
        tbl[3]  = '{4'b0000, 1, 4'b0010, 1, 1};
        tbl[4]  = '{4'b0000, 1, 4'b0000, 0, 0};
        tbl[5]  = '{4'b0000, 0, 4'b0000, 0, 0};
        tbl[6]  = '{4'b1011, 1, 4'b0000, 0, 0};
        tbl[7]  = '{4'b0000, 1, 4'b0000, 0, 0};
        tbl[8]  = '{4'b0000, 1, 4'b1011, 0, 0};
        tbl[9]  = '{4'b0000, 1, 4'b1011, 1, 3};
        tbl[10] = '{4'b0000, 1, 4'b0011, 0, 0};
        tbl[11] = '{4'b0000, 1, 4'b0011, 0, 0};
        tbl[12] = '{4'b0000, 1, 4'b0011, 1, 1};
        tbl[13] = '{4'b0000, 1, 4'b0001, 0, 0};
        tbl[14] = '{4'b0000, 1, 4'b0001, 0, 0};
        tbl[15] = '{4'b0000, 1, 4'b0001, 1, 0};
        tbl[16] = '{4'b0000, 1, 4'b0000, 0, 0};
        tbl[17] = '{4'b0000, 0, 4'b0000, 0, 0};
        for (int i = 0; i < 18; i++) begin
            req = tbl[i].req; rdy = tbl[i].rdy;
            tick();
            check($sformatf("tbl%0d_pending", i), p0, tbl[i].pend);
            check($sformatf("tbl%0d_valid", i), v0, tbl[i].valid);
            if (tbl[i].valid) check($sformatf("tbl%0d_id", i), id0, tbl[i].id);
        end

        // Test 3: masked higher line stays pending
        mask = 4'b0111; req = 4'b1100; tick(); req = 0;
        repeat (3) tick();
        check("t3_id2", id0, 2);
        check("t3_valid", v0, 1);
        check("t3_pend3", p0[3], 1);
        rdy = 1; tick(); rdy = 0; mask = 4'hF;
        repeat (2) tick();
        check("t3_id3", id0, 3);
        check("t3_valid3", v0, 1);
        rdy = 1; tick(); rdy = 0; repeat (2) tick();

        // Test 4: offer held across new request and mask drop
        req = 4'b0010; tick(); req = 0;
        repeat (3) tick();
        req = 4'b1000; mask = 4'b1101; tick(); req = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_id", id0, 1);
            check("t4_hold_valid", v0, 1);
        end
        rdy = 1; mask = 4'hF;
        repeat (6) tick();
        rdy = 0;

        // Test 5: lost requests, set-wins collision, saturation
        mask = 0; req = 4'b0100; tick(); req = 0; repeat (3) tick();
        for (int i = 0; i < 3; i++) begin req = 4'b0100; tick(); req = 0; tick(); end
        repeat (3) tick();
        check("t5_ovf3", o0, 3);
        req = 4'b0100; tick();
        req = 0; mask = 4'hF; rdy = 1; tick();
        check("t5_offer2", id0, 2);
        tick();
        check("t5_setwins_pend", p0[2], 1);
        check("t5_setwins_ovf", o0, 3);
        mask = 0; rdy = 0;
        for (int i = 0; i < 2; i++) begin req = 4'b0100; tick(); req = 0; tick(); end
        repeat (3) tick();
        check("t5_ovf5", o0, 5);
        check("t5_sat", o2, 3);

        // Test 6: async reset mid-offer
        mask = 4'hF; repeat (2) tick();
        check("t6_offer", v0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid_async", v0, 0);
        check("t6_pend_async", p0, 0);
        check("t6_ovf_async", o0, 0);
        check("t6_sat_async", o2, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Level mode: held line re-offers every 3 clocks with no loss counted
        req_l = 4'b0001; rdy_l = 1;
        tick();
        check("lvl_lat1", p1, 0);
        tick();
        check("lvl_lat2", p1, 1);
        offers = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (v1) offers++;
        end
        check("lvl_offers", offers, 10);
        check("lvl_ovf", o1, 0);
        check("lvl_pend", p1, 1);
        req_l = 0; rdy_l = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
            rdy = 1'($urandom_range(0, 1));
            tick();
        end
        req = 0; mask = 4'hF; rdy = 1;
        repeat (20) tick();
        check("drain_pending", p0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
